// File: rtl/calc1_port_responder.sv
// calc1_port_responder
//   Far-end model of one calc1 port. It takes a command with operand 1 in one
//   cycle and operand 2 in the next. After LATENCY cycles it returns a
//   one-cycle response code plus a result word.
// Ports
//   c_clk       : clock; all state changes on its rising edge
//   reset       : asynchronous reset, active low
//   req_cmd_in  : [0:3] command (0 nop, 1 add, 2 sub, 5 shl, 6 shr)
//   req_data_in : [0:31] operand 1 in the command cycle, operand 2 in the next
//   out_resp    : [0:1] 0 none, 1 ok, 2 over/underflow, 3 invalid
//   out_data    : [0:31] result; zero whenever out_resp is zero
//   busy        : registered; high from the operand-2 cycle through the response
// Bit 0 is the MSB on every [0:N] bus, so numeric values read normally.
module calc1_port_responder #(
  parameter int LATENCY = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OP2  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] op1_q, op1_d;
  logic [1:0]  rcode_q, rcode_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;

  // The result is computed in the operand-2 cycle straight from the bus.
  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [32:0] sum;
  logic [1:0]  res_code;
  logic [31:0] res_data;

  assign op2   = req_data_in;
  assign shamt = req_data_in[27:31];  // low five bits; the upper bits are ignored

  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, op2};
    res_code = 2'd3;
    res_data = '0;
    case (cmd_q)
      4'd1: begin
        if (sum[32]) res_code = 2'd2;
        else begin
          res_code = 2'd1;
          res_data = sum[31:0];
        end
      end
      4'd2: begin
        if (op2 > op1_q) res_code = 2'd2;
        else begin
          res_code = 2'd1;
          res_data = op1_q - op2;
        end
      end
      4'd5: begin
        res_code = 2'd1;
        res_data = op1_q << shamt;
      end
      4'd6: begin
        res_code = 2'd1;
        res_data = op1_q >> shamt;
      end
      default: begin
        res_code = 2'd3;
        res_data = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    rcode_d = rcode_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_cmd_in != 4'd0) begin
          cmd_d   = req_cmd_in;
          op1_d   = req_data_in;
          state_d = S_OP2;
        end
      end
      S_OP2: begin
        // Any command on the bus in this cycle is data-phase and is ignored.
        rcode_d = res_code;
        rdata_d = res_data;
        if (LATENCY == 1) state_d = S_RESP;
        else begin
          state_d = S_EXEC;
          cnt_d   = CNT_INIT;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
    // Registering the outputs from the next state keeps the response aligned
    // with the RESP state and leaves no combinational path from the inputs.
    resp_d = (state_d == S_RESP) ? rcode_d : 2'd0;
    data_d = (state_d == S_RESP) ? rdata_d : 32'd0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      op1_q   <= '0;
      rcode_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      rcode_q <= rcode_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign out_resp = resp_q;
  assign out_data = data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_calc1_port_responder.sv
module tb_calc1_port_responder;
  localparam int L = 3;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [0:3]  req_cmd_in = '0;
  logic [0:31] req_data_in = '0;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  calc1_port_responder #(.LATENCY(L)) dut (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .out_resp(out_resp), .out_data(out_data), .busy(busy)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  cmd2;   // value left on req_cmd_in during the operand-2 cycle
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one full transaction and checks busy and the response cycle by cycle.
  task automatic do_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] c2,
                       input logic [1:0] er, input logic [31:0] ed);
    @(negedge c_clk);
    req_cmd_in = c; req_data_in = a;
    @(negedge c_clk);
    chk({nm, " busy@op2"}, 32'(busy), 32'd1);
    chk({nm, " resp@op2"}, 32'(out_resp), 32'd0);
    req_cmd_in = c2; req_data_in = b;
    for (int k = 2; k <= L; k++) begin
      @(negedge c_clk);
      req_cmd_in = '0; req_data_in = '0;
      chk({nm, " resp@exec"}, 32'(out_resp), 32'd0);
      chk({nm, " busy@exec"}, 32'(busy), 32'd1);
    end
    @(negedge c_clk);
    chk({nm, " resp"}, 32'(out_resp), 32'(er));
    chk({nm, " data"}, out_data, ed);
    chk({nm, " busy@resp"}, 32'(busy), 32'd1);
    @(negedge c_clk);
    chk({nm, " resp after"}, 32'(out_resp), 32'd0);
    chk({nm, " data after"}, out_data, 32'd0);
    chk({nm, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{4'd1, 32'h5,        32'h7,        4'd0, 2'd1, 32'h0000000C};
    vecs[1]  = '{4'd1, 32'hFFFFFFFF, 32'h1,        4'd0, 2'd2, 32'h0};
    vecs[2]  = '{4'd2, 32'h3,        32'h5,        4'd0, 2'd2, 32'h0};
    vecs[3]  = '{4'd2, 32'h5,        32'h5,        4'd0, 2'd1, 32'h0};
    vecs[4]  = '{4'd5, 32'h1,        32'h1F,       4'd0, 2'd1, 32'h80000000};
    vecs[5]  = '{4'd6, 32'h80000000, 32'h21,       4'd0, 2'd1, 32'h40000000};
    vecs[6]  = '{4'd9, 32'h1234,     32'h1,        4'd0, 2'd3, 32'h0};
    vecs[7]  = '{4'd2, 32'h10,       32'h3,        4'd0, 2'd1, 32'h0000000D};
    vecs[8]  = '{4'd1, 32'h80000000, 32'h7FFFFFFF, 4'd0, 2'd1, 32'hFFFFFFFF};
    vecs[9]  = '{4'd3, 32'hAAAA,     32'h5555,     4'd0, 2'd3, 32'h0};
    vecs[10] = '{4'd15, 32'h1,       32'h1,        4'd0, 2'd3, 32'h0};
    vecs[11] = '{4'd5, 32'hF0F0F0F0, 32'hFFFFFFE4, 4'd0, 2'd1, 32'h0F0F0F00};
    vecs[12] = '{4'd6, 32'hF0000000, 32'h20,       4'd0, 2'd1, 32'hF0000000};
    vecs[13] = '{4'd1, 32'h100,      32'h23,       4'd2, 2'd1, 32'h00000123};

    // Reset state
    #12;
    chk("reset resp", 32'(out_resp), 32'd0);
    chk("reset data", out_data, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(negedge c_clk);
    reset = 1'b1;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].op1, vecs[i].op2,
            vecs[i].cmd2, vecs[i].resp, vecs[i].data);

    // A zero command never starts a transaction
    @(negedge c_clk);
    req_cmd_in = 4'd0; req_data_in = 32'hDEADBEEF;
    for (int k = 0; k < L + 3; k++) begin
      @(negedge c_clk);
      chk("nop busy", 32'(busy), 32'd0);
      chk("nop resp", 32'(out_resp), 32'd0);
    end
    req_data_in = '0;

    // A command issued while busy is dropped; re-issuing it later works
    @(negedge c_clk);
    req_cmd_in = 4'd1; req_data_in = 32'h20;
    @(negedge c_clk);
    req_cmd_in = 4'd0; req_data_in = 32'h2;
    @(negedge c_clk);
    req_cmd_in = 4'd2; req_data_in = 32'h50;   // T+2, while busy
    @(negedge c_clk);
    req_cmd_in = 4'd0; req_data_in = 32'h10;
    chk("busy cmd busy", 32'(busy), 32'd1);
    @(negedge c_clk);
    req_data_in = '0;
    chk("busy cmd add resp", 32'(out_resp), 32'd1);
    chk("busy cmd add data", out_data, 32'h22);
    do_op("sub reissue", 4'd2, 32'h50, 32'h10, 4'd0, 2'd1, 32'h40);
    // Check there was no stray response for the dropped sub
    for (int k = 0; k < L + 2; k++) begin
      @(negedge c_clk);
      chk("no stray resp", 32'(out_resp), 32'd0);
    end

    // Asynchronous reset in the middle of EXEC
    @(negedge c_clk);
    req_cmd_in = 4'd1; req_data_in = 32'h1;
    @(negedge c_clk);
    req_cmd_in = 4'd0; req_data_in = 32'h2;
    @(negedge c_clk);
    req_data_in = '0;
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset resp", 32'(out_resp), 32'd0);
    chk("async reset data", out_data, 32'd0);
    @(negedge c_clk);
    reset = 1'b1;
    for (int k = 0; k < L + 2; k++) begin
      @(negedge c_clk);
      chk("post-reset resp", 32'(out_resp), 32'd0);
      chk("post-reset busy", 32'(busy), 32'd0);
    end
    do_op("post-reset add", 4'd1, 32'h5, 32'h7, 4'd0, 2'd1, 32'h0000000C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
